// File: rtl/slide_fetch_scheduler_if.sv
// Shared image-ROM port: host read handshake plus the ROM address/data pair.
// master = environment (host + ROM), slave = slide_fetch_scheduler.
interface slide_fetch_scheduler_if #(
  parameter int ADDR_W = 18
);
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic              host_ack;
  logic [7:0]        host_rdata;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport master (
    output host_req, host_addr, rom_data,
    input  host_ack, host_rdata, rom_addr
  );

  modport slave (
    input  host_req, host_addr, rom_data,
    output host_ack, host_rdata, rom_addr
  );
endinterface

// File: rtl/slide_fetch_scheduler.sv
// Image-ROM read sequencer for 800x600 scanout of one of NUM_SLIDES slides placed
// at a frame-latched (x,y); a host reader gets the ROM port whenever scanout does not.
module slide_fetch_scheduler #(
  parameter int  IMG_W      = 168,
  parameter int  IMG_H      = 192,
  parameter int  NUM_SLIDES = 4,
  parameter int  ADDR_W     = 18,
  localparam int IDX_W      = (NUM_SLIDES > 1) ? $clog2(NUM_SLIDES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            hcount_i,
  input  logic [9:0]             vcount_i,
  input  logic                   frame_start_i,
  input  logic [10:0]            pos_x_i,
  input  logic [9:0]             pos_y_i,
  input  logic                   next_req_i,
  input  logic                   prev_req_i,
  slide_fetch_scheduler_if.slave bus,
  output logic                   pix_valid_o,
  output logic [IDX_W-1:0]       slide_idx_o
);

  localparam logic [ADDR_W-1:0] SLIDE_SZ  = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((NUM_SLIDES - 1) * IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SLIDES - 1);
  localparam logic [11:0]       WIN_W     = 12'(IMG_W);
  localparam logic [10:0]       WIN_H     = 11'(IMG_H);
  localparam logic [10:0]       H_ACTIVE  = 11'd800;
  localparam logic [10:0]       H_LAST    = 11'd1055;
  localparam logic [9:0]        V_ACTIVE  = 10'd600;

  typedef enum logic [0:0] {WAIT_FRAME, RUN} frame_state_e;
  typedef enum logic [1:0] {H_IDLE, H_ISSUE, H_ACK} host_state_e;

  frame_state_e      frame_q, frame_d;
  host_state_e       host_q, host_d;

  logic [10:0]       sx_q, sx_s;
  logic [9:0]        sy_q, sy_s;
  logic [IDX_W-1:0]  slide_idx_q, slide_idx_d, idx_step_s;
  logic [ADDR_W-1:0] slide_base_q, slide_base_d, base_step_s;
  logic [ADDR_W-1:0] row_base_q, row_base_s, row_base_d;
  logic              next_pend_q, next_pend_d, next_pend_s;
  logic              prev_pend_q, prev_pend_d, prev_pend_s;

  logic [11:0]       dx_s;
  logic [10:0]       dy_s;
  logic              col_in_s, row_in_s, run_s, in_win_s, grant_s;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              pix_valid_q, pix_valid_d;
  logic              host_ack_q, host_ack_d;
  logic [7:0]        host_rdata_q, host_rdata_d;

  // Frame-boundary view of configuration: on frame_start the new values apply to this very pixel.
  always_comb begin
    next_pend_s = next_pend_q | next_req_i;
    prev_pend_s = prev_pend_q | prev_req_i;
    idx_step_s  = slide_idx_q;
    base_step_s = slide_base_q;
    if (next_pend_s && !prev_pend_s) begin
      if (slide_idx_q == IDX_LAST) begin
        idx_step_s  = '0;
        base_step_s = '0;
      end else begin
        idx_step_s  = slide_idx_q + IDX_W'(1);
        base_step_s = slide_base_q + SLIDE_SZ;
      end
    end else if (prev_pend_s && !next_pend_s) begin
      if (slide_idx_q == '0) begin
        idx_step_s  = IDX_LAST;
        base_step_s = LAST_BASE;
      end else begin
        idx_step_s  = slide_idx_q - IDX_W'(1);
        base_step_s = slide_base_q - SLIDE_SZ;
      end
    end else begin
      idx_step_s  = slide_idx_q;
      base_step_s = slide_base_q;
    end

    if (frame_start_i) begin
      sx_s         = pos_x_i;
      sy_s         = pos_y_i;
      slide_idx_d  = idx_step_s;
      slide_base_d = base_step_s;
      row_base_s   = base_step_s;
      next_pend_d  = 1'b0;
      prev_pend_d  = 1'b0;
    end else begin
      sx_s         = sx_q;
      sy_s         = sy_q;
      slide_idx_d  = slide_idx_q;
      slide_base_d = slide_base_q;
      row_base_s   = row_base_q;
      next_pend_d  = next_pend_s;
      prev_pend_d  = prev_pend_s;
    end
  end

  // Window test and row-base stepping; the row base only moves on lines inside the slide rows.
  always_comb begin
    dx_s     = {1'b0, hcount_i} - {1'b0, sx_s};
    dy_s     = {1'b0, vcount_i} - {1'b0, sy_s};
    col_in_s = (hcount_i >= sx_s) && (dx_s < WIN_W) && (hcount_i < H_ACTIVE);
    row_in_s = (vcount_i >= sy_s) && (dy_s < WIN_H);
    run_s    = (frame_q == RUN) || frame_start_i;
    in_win_s = run_s && col_in_s && row_in_s && (vcount_i < V_ACTIVE);
    if ((hcount_i == H_LAST) && row_in_s) begin
      row_base_d = row_base_s + ROW_STEP;
    end else begin
      row_base_d = row_base_s;
    end
  end

  // Frame FSM: scanout stays muted until the first frame boundary after reset.
  always_comb begin
    frame_d = frame_q;
    case (frame_q)
      WAIT_FRAME: frame_d = frame_start_i ? RUN : WAIT_FRAME;
      RUN:        frame_d = RUN;
      default:    frame_d = WAIT_FRAME;
    endcase
  end

  // Host arbiter: grant only when the slot being registered now is not a slide pixel.
  always_comb begin
    host_d  = host_q;
    grant_s = 1'b0;
    case (host_q)
      H_IDLE: begin
        if (bus.host_req && !in_win_s) begin
          host_d  = H_ISSUE;
          grant_s = 1'b1;
        end else begin
          host_d  = H_IDLE;
        end
      end
      H_ISSUE: host_d = H_ACK;
      H_ACK:   host_d = H_IDLE;
      default: host_d = H_IDLE;
    endcase
  end

  // Next values of the registered ROM-side outputs.
  always_comb begin
    if (in_win_s) begin
      rom_addr_d = row_base_s + ADDR_W'(dx_s);
    end else if (grant_s) begin
      rom_addr_d = bus.host_addr;
    end else begin
      rom_addr_d = '0;
    end
    pix_valid_d = in_win_s;
    host_ack_d  = (host_q == H_ISSUE);
    if (host_q == H_ISSUE) begin
      host_rdata_d = bus.rom_data;
    end else begin
      host_rdata_d = host_rdata_q;
    end
  end

  // State registers of both FSMs.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= WAIT_FRAME;
      host_q  <= H_IDLE;
    end else begin
      frame_q <= frame_d;
      host_q  <= host_d;
    end
  end

  // Shadow configuration, slide selection, row base and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q         <= '0;
      sy_q         <= '0;
      slide_idx_q  <= '0;
      slide_base_q <= '0;
      row_base_q   <= '0;
      next_pend_q  <= 1'b0;
      prev_pend_q  <= 1'b0;
      rom_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
    end else begin
      sx_q         <= sx_s;
      sy_q         <= sy_s;
      slide_idx_q  <= slide_idx_d;
      slide_base_q <= slide_base_d;
      row_base_q   <= row_base_d;
      next_pend_q  <= next_pend_d;
      prev_pend_q  <= prev_pend_d;
      rom_addr_q   <= rom_addr_d;
      pix_valid_q  <= pix_valid_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.host_rdata = host_rdata_q;
  assign pix_valid_o    = pix_valid_q;
  assign slide_idx_o    = slide_idx_q;

endmodule
